// File: rtl/definitions_pkg.sv
// Shared ALU instruction definitions used by the issue unit and the ALU.
package definitions;

  typedef enum logic [1:0] {
    ADD = 2'd0,
    SUB = 2'd1,
    MUL = 2'd2
  } opcode_t;

  typedef struct packed {
    opcode_t     opcode;
    logic [31:0] a;
    logic [31:0] b;
  } instruction_t;

  localparam int RESULT_W = 32;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered occupancy count.
// The head entry is presented combinationally on dout.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             do_push, do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage write; contents need no reset since empty gates every read.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // A push into a full FIFO would silently lose data.
  a_no_overflow: assert property (@(posedge clock) disable iff (!reset_n) !(push && full));

endmodule

// File: rtl/alu_issue_unit.sv
// Issue side of the ALU instruction interface: buffers tagged instructions,
// drives IW one per cycle, and collects registered ALU results two edges
// later. Issue is gated by credits equal to the free result FIFO slots, since
// the ALU cannot be stalled once an instruction is on IW.
module alu_issue_unit
  import definitions::*;
#(
  parameter int IQ_DEPTH  = 4,
  parameter int RES_DEPTH = 4,
  parameter int TAG_W     = 4
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  instruction_t        in_instr,
  input  logic [TAG_W-1:0]    in_tag,
  output instruction_t        IW,
  input  logic [RESULT_W-1:0] alu_result,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [RESULT_W-1:0] res_data,
  output logic [TAG_W-1:0]    res_tag,
  output logic                busy
);

  localparam int IQ_W   = $bits(instruction_t) + TAG_W;
  localparam int RQ_W   = RESULT_W + TAG_W;
  localparam int CRED_W = $clog2(RES_DEPTH + 1);
  localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(RES_DEPTH);

  logic [IQ_W-1:0]   iq_dout;
  logic              iq_full, iq_empty;
  logic [RQ_W-1:0]   rq_dout;
  logic              rq_full, rq_empty;

  logic [CRED_W-1:0] credits;
  logic [TAG_W-1:0]  tag_s1, tag_s2;
  logic              v1, v2;
  logic              issue, res_pop;

  assign in_ready = !iq_full;
  assign issue    = !iq_empty && (credits != '0);
  assign res_pop  = res_valid && res_ready;

  sync_fifo #(.DEPTH(IQ_DEPTH), .WIDTH(IQ_W)) u_iq (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (in_valid && in_ready),
    .din     ({in_instr, in_tag}),
    .pop     (issue),
    .dout    (iq_dout),
    .full    (iq_full),
    .empty   (iq_empty)
  );

  sync_fifo #(.DEPTH(RES_DEPTH), .WIDTH(RQ_W)) u_rq (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (v2),
    .din     ({alu_result, tag_s2}),
    .pop     (res_pop),
    .dout    (rq_dout),
    .full    (rq_full),
    .empty   (rq_empty)
  );

  assign res_valid           = !rq_empty;
  assign {res_data, res_tag} = rq_dout;
  assign busy                = !iq_empty || v1 || v2 || res_valid;

  // Issue register plus the v1/v2 tracker that follows each op through the ALU.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      IW     <= '0;
      tag_s1 <= '0;
      v1     <= 1'b0;
      v2     <= 1'b0;
      tag_s2 <= '0;
    end else begin
      v1     <= issue;
      if (issue) {IW, tag_s1} <= iq_dout;
      v2     <= v1;
      tag_s2 <= tag_s1;
    end
  end

  // Credits: one taken per issue, one returned per downstream pop.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      credits <= CRED_MAX;
    end else begin
      case ({issue, res_pop})
        2'b10:   credits <= credits - 1'b1;
        2'b01:   credits <= credits + 1'b1;
        default: credits <= credits;
      endcase
    end
  end

  a_credit_max: assert property (@(posedge clock) disable iff (!reset_n) credits <= CRED_MAX);
  a_capture_room: assert property (@(posedge clock) disable iff (!reset_n) !(v2 && rq_full));

endmodule

// File: tb/tb_alu_issue_unit.sv
// Bench for alu_issue_unit with a behavioural registered ALU alongside it.
// An order queue of expected {result, tag} is filled on every accepted
// instruction and drained against every returned result.
module tb_alu_issue_unit;
  import definitions::*;

  localparam int TAG_W = 4;

  logic                clock = 1'b0;
  logic                reset_n = 1'b0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  instruction_t        in_instr = '0;
  logic [TAG_W-1:0]    in_tag = '0;
  instruction_t        IW;
  logic [31:0]         alu_result;
  logic                res_valid;
  logic                res_ready = 1'b0;
  logic [31:0]         res_data;
  logic [TAG_W-1:0]    res_tag;
  logic                busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_res = 0;

  typedef struct {
    logic [31:0]      d;
    logic [TAG_W-1:0] t;
  } res_t;

  res_t exp_q[$];
  res_t got_q[$];
  int   pop_cyc[$];

  alu_issue_unit #(.IQ_DEPTH(4), .RES_DEPTH(4), .TAG_W(TAG_W)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .in_tag     (in_tag),
    .IW         (IW),
    .alu_result (alu_result),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_tag    (res_tag),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] alu_f(input opcode_t op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      ADD:     return a + b;
      SUB:     return a - b;
      MUL:     return a * b;
      default: return 32'h0;
    endcase
  endfunction

  // The ALU: one registered stage computing from IW.
  always_ff @(posedge clock) alu_result <= alu_f(IW.opcode, IW.a, IW.b);

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tg, input logic [95:0] obs, input logic [95:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tg, obs, exp);
    end
  endtask

  // Handshake monitor, sampled mid-cycle so inputs and outputs are settled.
  always @(negedge clock) begin
    if (!reset_n) begin
      exp_q.delete();
    end else begin
      if (in_valid && in_ready)
        exp_q.push_back('{d: alu_f(in_instr.opcode, in_instr.a, in_instr.b), t: in_tag});
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_result", {64'd0, res_data}, 96'hdead_0000);
        end else begin
          res_t e;
          e = exp_q.pop_front();
          chk("res_data", {64'd0, res_data}, {64'd0, e.d});
          chk("res_tag", {92'd0, res_tag}, {92'd0, e.t});
        end
        got_q.push_back('{d: res_data, t: res_tag});
        pop_cyc.push_back(cyc);
        n_res++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Present one instruction and hold it until it is accepted; in_valid stays up.
  task automatic send(input opcode_t op, input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] tg);
    int  n;
    logic hs;
    in_valid        = 1'b1;
    in_instr.opcode = op;
    in_instr.a      = a;
    in_instr.b      = b;
    in_tag          = tg;
    n  = 0;
    hs = 1'b0;
    while (!hs && n < 100) begin
      @(negedge clock);
      hs = in_ready;
      @(posedge clock);
      #1;
      n++;
    end
    if (!hs) chk("send_timeout", {95'd0, hs}, 96'd1);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_instr = 'x;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < 2000) begin
      tick(1);
      n++;
    end
    if (n >= 2000) chk("drain_timeout", {95'd0, busy}, 96'd0);
  endtask

  instruction_t bp_ins[10];

  initial begin
    int base;
    int ok;

    // Reset state
    #2;
    chk("rst_IW", {30'd0, IW}, 96'd0);
    chk("rst_res_valid", {95'd0, res_valid}, 96'd0);
    chk("rst_in_ready", {95'd0, in_ready}, 96'd1);
    chk("rst_busy", {95'd0, busy}, 96'd0);
    #21 reset_n = 1'b1;
    tick(2);

    // Single op: accept at edge 0, result visible after edge 3
    res_ready = 1'b1;
    send(ADD, 32'd5, 32'd7, 4'd3);
    idle();
    chk("single_e0_valid", {95'd0, res_valid}, 96'd0);
    tick(1);
    chk("single_e1_valid", {95'd0, res_valid}, 96'd0);
    tick(1);
    chk("single_e2_valid", {95'd0, res_valid}, 96'd0);
    tick(1);
    chk("single_e3_valid", {95'd0, res_valid}, 96'd1);
    chk("single_data", {64'd0, res_data}, 96'd12);
    chk("single_tag", {92'd0, res_tag}, 96'd3);
    chk("single_busy", {95'd0, busy}, 96'd1);
    tick(1);
    chk("single_busy_after_pop", {95'd0, busy}, 96'd0);
    chk("single_valid_after_pop", {95'd0, res_valid}, 96'd0);

    // Back-to-back: eight ops, results one per cycle in order
    got_q.delete();
    pop_cyc.delete();
    send(SUB, 32'd10, 32'd3, 4'd0);
    send(MUL, 32'd6, 32'd7, 4'd1);
    send(ADD, 32'hFFFF_FFFF, 32'd1, 4'd2);
    send(ADD, 32'd100, 32'd23, 4'd3);
    send(SUB, 32'd5, 32'd5, 4'd4);
    send(MUL, 32'hFFFF_FFFF, 32'd2, 4'd5);
    send(SUB, 32'd0, 32'd2, 4'd6);
    send(MUL, 32'h0001_0000, 32'h0001_0000, 4'd7);
    idle();
    wait_drain();
    begin
      logic [31:0] b2b_exp [8];
      b2b_exp = '{32'd7, 32'd42, 32'd0, 32'd123, 32'd0, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'd0};
      chk("b2b_count", 96'(got_q.size()), 96'd8);
      for (int i = 0; i < 8 && i < got_q.size(); i++) begin
        chk("b2b_data", {64'd0, got_q[i].d}, {64'd0, b2b_exp[i]});
        chk("b2b_tag", {92'd0, got_q[i].t}, 96'(i));
        chk("b2b_no_bubble", 96'(pop_cyc[i] - pop_cyc[0]), 96'(i));
      end
    end

    // Backpressure: credits stop issue after four, iq fills after four more
    res_ready = 1'b0;
    base = n_res;
    for (int i = 0; i < 10; i++) begin
      bp_ins[i].opcode = ADD;
      bp_ins[i].a      = $urandom;
      bp_ins[i].b      = $urandom;
    end
    for (int i = 0; i < 8; i++)
      send(bp_ins[i].opcode, bp_ins[i].a, bp_ins[i].b, 4'(i));
    idle();
    tick(5);
    chk("bp_in_ready_full", {95'd0, in_ready}, 96'd0);
    chk("bp_res_valid", {95'd0, res_valid}, 96'd1);
    chk("bp_IW_stops_at_4th", {30'd0, IW}, {30'd0, bp_ins[3]});
    chk("bp_busy", {95'd0, busy}, 96'd1);

    // One pop on a full result FIFO releases exactly one issue
    res_ready = 1'b1;
    tick(1);
    res_ready = 1'b0;
    tick(3);
    chk("sim_IW_one_issue", {30'd0, IW}, {30'd0, bp_ins[4]});
    chk("sim_in_ready", {95'd0, in_ready}, 96'd1);
    chk("sim_head_tag", {92'd0, res_tag}, 96'd1);
    chk("sim_one_pop", 96'(n_res - base), 96'd1);
    send(bp_ins[8].opcode, bp_ins[8].a, bp_ins[8].b, 4'd8);
    idle();
    tick(2);
    chk("sim_in_ready_refull", {95'd0, in_ready}, 96'd0);
    chk("sim_IW_held", {30'd0, IW}, {30'd0, bp_ins[4]});
    res_ready = 1'b1;
    send(bp_ins[9].opcode, bp_ins[9].a, bp_ins[9].b, 4'd9);
    idle();
    wait_drain();
    chk("bp_all_results", 96'(n_res - base), 96'd10);

    // Reset with three ops in flight
    send(ADD, 32'd1, 32'd2, 4'd1);
    send(SUB, 32'd9, 32'd4, 4'd2);
    send(MUL, 32'd3, 32'd3, 4'd3);
    idle();
    #1 reset_n = 1'b0;
    #1;
    chk("mid_rst_res_valid", {95'd0, res_valid}, 96'd0);
    chk("mid_rst_IW", {30'd0, IW}, 96'd0);
    chk("mid_rst_busy", {95'd0, busy}, 96'd0);
    chk("mid_rst_in_ready", {95'd0, in_ready}, 96'd1);
    tick(2);
    #2 reset_n = 1'b1;
    tick(1);
    base = n_res;
    got_q.delete();
    send(ADD, 32'd1, 32'd1, 4'd9);
    idle();
    tick(10);
    chk("post_rst_count", 96'(n_res - base), 96'd1);
    if (got_q.size() > 0) begin
      chk("post_rst_data", {64'd0, got_q[0].d}, 96'd2);
      chk("post_rst_tag", {92'd0, got_q[0].t}, 96'd9);
    end
    chk("post_rst_busy", {95'd0, busy}, 96'd0);

    // Wrap-around and truncation
    got_q.delete();
    send(MUL, 32'h0001_0000, 32'h0001_0000, 4'd4);
    send(SUB, 32'd0, 32'd1, 4'd5);
    idle();
    wait_drain();
    chk("wrap_count", 96'(got_q.size()), 96'd2);
    if (got_q.size() == 2) begin
      chk("wrap_mul", {64'd0, got_q[0].d}, 96'd0);
      chk("wrap_sub", {64'd0, got_q[1].d}, 96'hFFFF_FFFF);
    end

    // Randomized traffic with random gaps and backpressure
    base = n_res;
    ok   = 0;
    in_valid = 1'b0;
    for (int c = 0; c < 600; c++) begin
      logic hs;
      @(negedge clock);
      hs = in_valid && in_ready;
      if (hs) ok++;
      @(posedge clock);
      #1;
      if (!in_valid || hs) begin
        in_valid = (c < 560) && ($urandom_range(0, 3) != 0);
        if (in_valid) begin
          in_instr.opcode = opcode_t'($urandom_range(0, 2));
          in_instr.a      = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
          in_instr.b      = $urandom;
          in_tag          = 4'($urandom);
        end else begin
          in_instr = 'x;
        end
      end
      res_ready = ($urandom_range(0, 2) != 0);
    end
    idle();
    res_ready = 1'b1;
    wait_drain();
    chk("rand_all_returned", 96'(n_res - base), 96'(ok));
    chk("end_busy", {95'd0, busy}, 96'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_issue_unit.md
Name: alu_issue_unit

Overview:
- Initiator side of the ALU's instruction interface.
- Accepts tagged instructions from upstream through a valid/ready handshake and buffers them.
- Drives the ALU's IW bus one instruction per cycle, and collects each registered ALU result with its tag.
- Returns results downstream through a second valid/ready handshake, using credit-based flow control because the ALU has no stall input.

Parameters:
- IQ_DEPTH, 4, instruction FIFO depth (power of 2, >=2)
- RES_DEPTH, 4, result FIFO depth and issue credit count (power of 2, >=2)
- TAG_W, 4, width of the caller-supplied tag

Ports:
- clock  in  1  single clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  instruction FIFO can accept
- in_instr  in  definitions::instruction_t  opcode, a, b
- in_tag  in  TAG_W  tag returned with the result
- IW  out  definitions::instruction_t  registered instruction to the ALU
- alu_result  in  32  ALU result port, registered inside the ALU
- res_valid  out  1  result FIFO non-empty
- res_ready  in  1  downstream accepts result
- res_data  out  32  result at head of result FIFO
- res_tag  out  TAG_W  tag at head of result FIFO
- busy  out  1  any instruction queued, in flight, or unread

Behaviour:
- Reset (async assert, sync deassert):
  - IW='0, res_valid=0, in_ready=1, busy=0.
  - Both FIFOs empty, credits=RES_DEPTH.
  - All in-flight instructions are dropped; a reset mid-operation produces no result for any instruction accepted before it.
- Accept: push when in_valid && in_ready.
  - in_ready = !iq_full only; a pop in the same cycle does not raise in_ready.
- Issue (edge k): when iq non-empty && credits>0:
  - pop iq, load IW/tag_s1 from the head, set v1=1, credits-1.
  - Otherwise v1=0 and IW holds its last value.
- ALU stage (edge k+1): ALU computes alu_result from IW; v2<=v1, tag_s2<=tag_s1.
- Capture (edge k+2): if v2, push {alu_result, tag_s2} into the result FIFO. Credits guarantee the push never hits a full FIFO; an overflow is an assertion failure.
- Timing:
  - Minimum latency: in-handshake at edge 0, issue at edge 1, ALU at edge 2, capture at edge 3; res_valid high after edge 3.
  - Throughput: 1 instruction/cycle while credits are available.
- Return: pop on res_valid && res_ready, credits+1 at the same edge.
  - Issue and pop on the same edge leave credits unchanged.
  - Credits never exceed RES_DEPTH and never go below 0.
- Results are returned strictly in issue order; tags are opaque.
- Arithmetic is done by the ALU: 32-bit, wrap-around on ADD/SUB, MUL result truncated to 32 bits. This block does not modify data.
- busy = !iq_empty || v1 || v2 || res_valid.
- in_instr, in_tag, res_ready are sampled only at edges; X on in_instr while in_valid=0 must not propagate.

Decomposition:
- Package definitions (shared):
  - opcode_t enum (ADD, SUB, MUL) and instruction_t struct {opcode, a[31:0], b[31:0]}, both existing.
  - New: localparam RESULT_W=32.
- Sub-module sync_fifo (parameters DEPTH, WIDTH; push/pop/full/empty, same clock and reset_n), instantiated twice:
  - instruction FIFO, WIDTH = instruction_t + TAG_W
  - result FIFO, WIDTH = 32 + TAG_W
- Credit counter, issue register and v1/v2 pipeline live in alu_issue_unit.
- The bench instantiates alu_issue_unit together with the ALU.

Test Plan:
- Single op: ADD a=5 b=7 tag=3, res_ready=1 -> res_valid rises 3 cycles after accept with res_data=12, res_tag=3; busy falls the cycle after the pop.
- Back-to-back: 8 ops (SUB 10-3, MUL 6*7, ADD 0xFFFFFFFF+1, ...), tags 0..7, res_ready=1 -> results 7, 42, 0, ... in order, one per cycle, no bubbles.
- Backpressure: res_ready=0, push 10 ops:
  - exactly RES_DEPTH=4 results held, IW issue stops after 4.
  - iq fills (in_ready=0) after 4 more.
  - release res_ready -> all 10 results in order, none lost or duplicated.
- Simultaneous: result FIFO full, iq non-empty, res_ready=1 for one cycle -> one pop, then exactly one issue; credits return to 0, never overflow.
- Reset mid-operation: assert reset_n=0 with 3 ops in flight -> immediately res_valid=0, IW=0, busy=0. After release, ADD 1+1 tag=9 -> single result 2 with tag 9, no stale results.
- Wrap/MUL: MUL a=0x10000 b=0x10000 -> res_data=0; SUB a=0 b=1 -> 0xFFFFFFFF.
